sd_cmd_framer: RTL

Upstream command stage for spi_master in the SD-card SPI path. Accepts a command index and 32-bit argument, builds the 48-bit SD command frame with a bit-serially computed CRC7, and launches it through spi_master. It then sends all-ones poll transfers until an R1 response byte appears, or until a poll limit is reached. The R1 byte, or a timeout flag, is returned to the host controller.

---
 rtl/sd_spi_pkg.sv | 45 ++++
 rtl/sd_crc7_serial.sv | 29 ++
 rtl/sd_cmd_framer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI command path.
package sd_spi_pkg;

    // Command framer sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC,
        ST_SEND,
        ST_WAIT_CMD,
        ST_POLL_SEND,
        ST_POLL_WAIT,
        ST_RESP
    } framer_state_t;

    localparam int          SD_FRAME_W = 48;
    localparam int          SD_BODY_W  = 40;      // start + tx + index + argument
    localparam logic [5:0]  CRC_LAST   = 6'd39;   // index of the final body bit fed to the CRC
    localparam logic [6:0]  CRC7_POLY  = 7'h09;   // x^7 + x^3 + 1, x^7 term implicit
    localparam logic [SD_FRAME_W-1:0] POLL_FILL = 48'hFFFF_FFFF_FFFF;

    localparam logic START_BIT = 1'b0;
    localparam logic TX_BIT    = 1'b1;
    localparam logic END_BIT   = 1'b1;

    // Result of scanning a poll transfer for an R1 byte.
    typedef struct packed {
        logic       found;
        logic [7:0] r1;
    } r1_scan_t;

    // First byte (MSB byte first) with bit 7 clear is the R1 response.
    function automatic r1_scan_t find_r1(input logic [SD_FRAME_W-1:0] data);
        r1_scan_t res;
        res.found = 1'b0;
        res.r1    = 8'hFF;
        for (int i = SD_FRAME_W/8 - 1; i >= 0; i--) begin
            if (!res.found && !data[i*8 + 7]) begin
                res.found = 1'b1;
                res.r1    = data[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1) for SD command frames, MSB first.
module sd_crc7_serial
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [6:0] crc_out
);

    logic fb;

    assign fb = crc_out[6] ^ data_in;

    // Shift one message bit per enabled cycle; clear wins over enable.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_out <= 7'h00;
        end else if (clear) begin
            crc_out <= 7'h00;
        end else if (enable) begin
            crc_out <= {crc_out[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_framer.sv
// Builds SD command frames, launches them through spi_master and polls for R1.
module sd_cmd_framer
    import sd_spi_pkg::*;
#(
    parameter int unsigned MAX_POLL = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [5:0]            cmd_index,
    input  logic [31:0]           cmd_arg,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_r1,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  spi_start,
    output logic [SD_FRAME_W-1:0] spi_write_data,
    input  logic [SD_FRAME_W-1:0] spi_read_data,
    input  logic                  spi_done
);

    framer_state_t        state;
    logic [SD_BODY_W-1:0] body_sr;   // rotated once per CRC cycle, back in place after 40
    logic [5:0]           bit_cnt;
    logic [7:0]           poll_cnt;
    logic [6:0]           crc;
    logic                 accept;
    r1_scan_t             scan;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign scan      = find_r1(spi_read_data);

    sd_crc7_serial u_crc (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (state == ST_CRC),
        .data_in (body_sr[SD_BODY_W-1]),
        .crc_out (crc)
    );

    // Command sequencing with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            body_sr        <= '0;
            bit_cnt        <= '0;
            poll_cnt       <= '0;
            spi_start      <= 1'b0;
            spi_write_data <= '0;
            rsp_valid      <= 1'b0;
            rsp_r1         <= 8'hFF;
            rsp_timeout    <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        body_sr  <= {START_BIT, TX_BIT, cmd_index, cmd_arg};
                        bit_cnt  <= '0;
                        poll_cnt <= '0;
                        state    <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    body_sr <= {body_sr[SD_BODY_W-2:0], body_sr[SD_BODY_W-1]};
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == CRC_LAST) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // The CRC register holds the final value only from this cycle on.
                    spi_write_data <= {body_sr, crc, END_BIT};
                    spi_start      <= 1'b1;
                    state          <= ST_WAIT_CMD;
                end
                ST_WAIT_CMD: begin
                    if (spi_done) begin
                        spi_write_data <= POLL_FILL;
                        state          <= ST_POLL_SEND;
                    end
                end
                ST_POLL_SEND: begin
                    spi_start <= 1'b1;
                    poll_cnt  <= poll_cnt + 8'd1;
                    state     <= ST_POLL_WAIT;
                end
                ST_POLL_WAIT: begin
                    if (spi_done) begin
                        if (scan.found) begin
                            rsp_r1      <= scan.r1;
                            rsp_timeout <= 1'b0;
                            rsp_valid   <= 1'b1;
                            state       <= ST_RESP;
                        end else if (poll_cnt == 8'(MAX_POLL)) begin
                            rsp_r1      <= 8'hFF;
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            state <= ST_POLL_SEND;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
